// File: rtl/camera_word_packer_if.sv
// Bundle of the camera byte stream, the Nios-facing group words and the group handshake.
//   cam_vsync, cam_href, cam_byte_valid, cam_byte : raw camera byte stream
//   group_ack, ovf_clr                            : Nios read acknowledge / overflow clear
//   camera_word_0..9                              : RGB555 pixels of the published group
//   group_valid, frame_start, overflow            : group status, frame pulse, sticky drop flag
//   group_count                                   : number of groups published (wrapping)
// master: the packer (producer of the words); slave: the consumer side.
interface camera_word_packer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             cam_vsync;
  logic             cam_href;
  logic             cam_byte_valid;
  logic [7:0]       cam_byte;
  logic             group_ack;
  logic             ovf_clr;
  logic [14:0]      camera_word_0;
  logic [14:0]      camera_word_1;
  logic [14:0]      camera_word_2;
  logic [14:0]      camera_word_3;
  logic [14:0]      camera_word_4;
  logic [14:0]      camera_word_5;
  logic [14:0]      camera_word_6;
  logic [14:0]      camera_word_7;
  logic [14:0]      camera_word_8;
  logic [14:0]      camera_word_9;
  logic             group_valid;
  logic             frame_start;
  logic             overflow;
  logic [CNT_W-1:0] group_count;

  modport master (
    input  cam_vsync, cam_href, cam_byte_valid, cam_byte, group_ack, ovf_clr,
    output camera_word_0, camera_word_1, camera_word_2, camera_word_3, camera_word_4,
           camera_word_5, camera_word_6, camera_word_7, camera_word_8, camera_word_9,
           group_valid, frame_start, overflow, group_count
  );

  modport slave (
    output cam_vsync, cam_href, cam_byte_valid, cam_byte, group_ack, ovf_clr,
    input  camera_word_0, camera_word_1, camera_word_2, camera_word_3, camera_word_4,
           camera_word_5, camera_word_6, camera_word_7, camera_word_8, camera_word_9,
           group_valid, frame_start, overflow, group_count
  );
endinterface

// File: rtl/camera_word_packer.sv
// Packs the 8-bit RGB565 camera byte stream into RGB555 pixels, collects groups of ten and
// publishes each group atomically to ten output words with a valid/ack handshake.
//   clk_clk     : system clock, rising edge
//   reset_reset : synchronous active-high reset
//   bus         : camera_word_packer_if master (byte stream in, group words/status out)
module camera_word_packer #(
  parameter bit          HI_FIRST = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  camera_word_packer_if.master  bus
);

  typedef enum logic [1:0] {StHi, StLo, StFull} state_e;

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       first_q, first_d;
  logic [14:0]      shadow_q [10];
  logic [14:0]      shadow_d [10];
  logic [14:0]      word_q   [10];
  logic [14:0]      word_d   [10];
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             fs_q, fs_d;
  logic             vsync_q;

  logic        qualified;
  logic        accept;
  logic        buf_free;
  logic        publish;
  logic [15:0] pix565;
  logic [14:0] pix555;

  assign qualified = bus.cam_byte_valid & bus.cam_href & ~bus.cam_vsync;
  assign accept    = qualified & (state_q != StFull);
  assign buf_free  = ~valid_q | bus.group_ack;
  assign pix565    = HI_FIRST ? {first_q, bus.cam_byte} : {bus.cam_byte, first_q};
  // Green LSB is dropped to fit 5:5:5.
  assign pix555    = {pix565[15:11], pix565[10:6], pix565[4:0]};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    first_d  = first_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    valid_d  = valid_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    publish  = 1'b0;
    fs_d     = vsync_q & ~bus.cam_vsync;

    case (state_q)
      StHi: begin
        if (bus.cam_vsync) begin
          idx_d = 4'd0;
        end else if (accept) begin
          first_d = bus.cam_byte;
          state_d = StLo;
        end
      end
      StLo: begin
        if (bus.cam_vsync) begin
          idx_d   = 4'd0;
          state_d = StHi;
        end else if (!bus.cam_href) begin
          // Half pixel lost at end of line; idx kept so groups span lines.
          state_d = StHi;
        end else if (accept) begin
          state_d = StHi;
          if (idx_q < 4'd9) begin
            shadow_d[idx_q] = pix555;
            idx_d           = idx_q + 4'd1;
          end else if (buf_free) begin
            word_d    = shadow_q;
            word_d[9] = pix555;
            publish   = 1'b1;
            idx_d     = 4'd0;
          end else begin
            shadow_d[9] = pix555;
            state_d     = StFull;
          end
        end
      end
      StFull: begin
        if (qualified) begin
          ovf_d = 1'b1;
        end
        // valid_q is always set here, so an ack frees the buffer.
        if (bus.group_ack) begin
          word_d  = shadow_q;
          publish = 1'b1;
          idx_d   = 4'd0;
          state_d = StHi;
        end
      end
      default: state_d = StHi;
    endcase

    if (publish) begin
      valid_d = 1'b1;
      count_d = count_q + 1'b1;
    end else if (bus.group_ack) begin
      valid_d = 1'b0;
    end

    // Set wins over a simultaneous clear.
    if (bus.ovf_clr && !(state_q == StFull && qualified)) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= StHi;
      idx_q   <= 4'd0;
      first_q <= 8'd0;
      for (int i = 0; i < 10; i++) begin
        shadow_q[i] <= 15'd0;
        word_q[i]   <= 15'd0;
      end
      valid_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      fs_q    <= 1'b0;
      vsync_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      first_q  <= first_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      fs_q     <= fs_d;
      vsync_q  <= bus.cam_vsync;
    end
  end

  assign bus.camera_word_0 = word_q[0];
  assign bus.camera_word_1 = word_q[1];
  assign bus.camera_word_2 = word_q[2];
  assign bus.camera_word_3 = word_q[3];
  assign bus.camera_word_4 = word_q[4];
  assign bus.camera_word_5 = word_q[5];
  assign bus.camera_word_6 = word_q[6];
  assign bus.camera_word_7 = word_q[7];
  assign bus.camera_word_8 = word_q[8];
  assign bus.camera_word_9 = word_q[9];
  assign bus.group_valid   = valid_q;
  assign bus.frame_start   = fs_q;
  assign bus.overflow      = ovf_q;
  assign bus.group_count   = count_q;

endmodule

// File: tb/tb_camera_word_packer.sv
module tb_camera_word_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  camera_word_packer_if #(.CNT_W(16)) bus ();

  camera_word_packer #(
    .HI_FIRST (1'b1),
    .CNT_W    (16)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus)
  );

  // Test pixels; group 0 carries the white and pure-red corner cases.
  function automatic logic [15:0] pix(input int g, input int k);
    if (g == 0 && k == 8) return 16'hFFFF;
    if (g == 0 && k == 9) return 16'hF800;
    return 16'((g * 16'h1357) + (k * 16'h0843) + 16'h0021);
  endfunction

  function automatic logic [14:0] rgb555(input logic [15:0] p);
    return {p[15:11], p[10:6], p[4:0]};
  endfunction

  function automatic logic [14:0] word_out(input int k);
    case (k)
      0: return bus.camera_word_0;
      1: return bus.camera_word_1;
      2: return bus.camera_word_2;
      3: return bus.camera_word_3;
      4: return bus.camera_word_4;
      5: return bus.camera_word_5;
      6: return bus.camera_word_6;
      7: return bus.camera_word_7;
      8: return bus.camera_word_8;
      default: return bus.camera_word_9;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    bus.cam_byte_valid = 1'b1;
    bus.cam_byte       = b;
    step();
    bus.cam_byte_valid = 1'b0;
  endtask

  task automatic put_pix(input logic [15:0] p);
    put(p[15:8]);
    put(p[7:0]);
  endtask

  task automatic send_group(input int g, input bit ack_last);
    for (int k = 0; k < 9; k++) put_pix(pix(g, k));
    put(pix(g, 9)[15:8]);
    bus.group_ack = ack_last;
    put(pix(g, 9)[7:0]);
    bus.group_ack = 1'b0;
  endtask

  task automatic check_group(input string tag, input int g);
    for (int k = 0; k < 10; k++) chk($sformatf("%s_w%0d", tag, k), 32'(word_out(k)),
                                     32'(rgb555(pix(g, k))));
  endtask

  task automatic ack_pulse();
    bus.group_ack = 1'b1;
    step();
    bus.group_ack = 1'b0;
  endtask

  initial begin
    bus.cam_vsync      = 1'b1;
    bus.cam_href       = 1'b1;
    bus.cam_byte_valid = 1'b0;
    bus.cam_byte       = 8'h00;
    bus.group_ack      = 1'b0;
    bus.ovf_clr        = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_valid", 32'(bus.group_valid), 0);
    chk("rst_count", 32'(bus.group_count), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_fs", 32'(bus.frame_start), 0);
    chk("rst_w0", 32'(bus.camera_word_0), 0);
    chk("rst_w9", 32'(bus.camera_word_9), 0);
    rst = 1'b0;
    step();
    chk("fs_vsync_high", 32'(bus.frame_start), 0);
    bus.cam_vsync = 1'b0;
    step();
    chk("fs_pulse", 32'(bus.frame_start), 1);
    step();
    chk("fs_one_cycle", 32'(bus.frame_start), 0);

    // Group with ack held high throughout
    bus.group_ack = 1'b1;
    for (int k = 0; k < 9; k++) put_pix(pix(0, k));
    put(8'hF8);
    chk("g0_valid_before", 32'(bus.group_valid), 0);
    put(8'h00);
    chk("g0_valid", 32'(bus.group_valid), 1);
    chk("g0_count", 32'(bus.group_count), 1);
    check_group("g0", 0);
    chk("white", 32'(bus.camera_word_8), 32'h7FFF);
    chk("red", 32'(bus.camera_word_9), 32'h7C00);
    step();
    chk("g0_acked", 32'(bus.group_valid), 0);
    bus.group_ack = 1'b0;

    // Two groups without ack: second waits in FULL
    send_group(1, 1'b0);
    chk("g1_count", 32'(bus.group_count), 2);
    send_group(2, 1'b0);
    chk("full_count", 32'(bus.group_count), 2);
    chk("full_valid", 32'(bus.group_valid), 1);
    check_group("g1_stable", 1);
    chk("full_no_ovf", 32'(bus.overflow), 0);
    bus.ovf_clr = 1'b1;
    put(8'hAA);
    bus.ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(bus.overflow), 1);
    check_group("g1_after_drop", 1);
    ack_pulse();
    chk("g2_valid", 32'(bus.group_valid), 1);
    chk("g2_count", 32'(bus.group_count), 3);
    check_group("g2", 2);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    chk("ovf_clr", 32'(bus.overflow), 0);

    // Ack coincides with the 10th low byte while valid
    send_group(3, 1'b1);
    chk("g3_valid", 32'(bus.group_valid), 1);
    chk("g3_count", 32'(bus.group_count), 4);
    chk("g3_no_ovf", 32'(bus.overflow), 0);
    check_group("g3", 3);
    ack_pulse();
    chk("g3_acked", 32'(bus.group_valid), 0);

    // VSYNC discards a partial group
    for (int k = 0; k < 7; k++) put_pix(pix(9, k));
    put(8'h5A);
    bus.cam_vsync = 1'b1;
    step();
    chk("fs_on_rise", 32'(bus.frame_start), 0);
    step();
    bus.cam_vsync = 1'b0;
    step();
    chk("fs_frame2", 32'(bus.frame_start), 1);
    send_group(4, 1'b0);
    chk("fs_after", 32'(bus.frame_start), 0);
    chk("g4_count", 32'(bus.group_count), 5);
    check_group("g4", 4);
    ack_pulse();

    // HREF drop between hi and lo byte of pixel 3
    for (int k = 0; k < 3; k++) put_pix(pix(5, k));
    put(8'h12);
    bus.cam_href = 1'b0;
    step();
    step();
    bus.cam_href = 1'b1;
    for (int k = 3; k < 10; k++) put_pix(pix(5, k));
    chk("g5_valid", 32'(bus.group_valid), 1);
    chk("g5_count", 32'(bus.group_count), 6);
    check_group("g5", 5);
    ack_pulse();

    // Reset while FULL
    send_group(6, 1'b0);
    send_group(7, 1'b0);
    rst = 1'b1;
    bus.cam_vsync = 1'b1;
    step();
    chk("rst2_valid", 32'(bus.group_valid), 0);
    chk("rst2_count", 32'(bus.group_count), 0);
    chk("rst2_w0", 32'(bus.camera_word_0), 0);
    chk("rst2_w9", 32'(bus.camera_word_9), 0);
    rst = 1'b0;
    step();
    bus.cam_vsync = 1'b0;
    step();
    send_group(8, 1'b0);
    chk("g8_valid", 32'(bus.group_valid), 1);
    chk("g8_count", 32'(bus.group_count), 1);
    check_group("g8", 8);
    ack_pulse();

    // Counter wrap
    force dut.count_q = 16'hFFFF;
    step();
    release dut.count_q;
    step();
    chk("cnt_preset", 32'(bus.group_count), 32'hFFFF);
    send_group(10, 1'b0);
    chk("cnt_wrap", 32'(bus.group_count), 0);
    chk("wrap_valid", 32'(bus.group_valid), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
